// File: rtl/data_mem_io_if.sv
// Processor-side load/store bus and board I/O of the data memory block.
// The top module keeps flat ports; this bundles them for the bench and for parent designs.
interface data_mem_io_if;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [9:0]  Switches;
    logic [9:0]  Leds;
    logic        TimerIrq;

    modport master (
        output MemWrite, ALUResult, WriteData, Switches,
        input  ReadData, Leds, TimerIrq
    );

    modport slave (
        input  MemWrite, ALUResult, WriteData, Switches,
        output ReadData, Leds, TimerIrq
    );
endinterface

// File: rtl/data_mem_io.sv
// Data RAM plus memory-mapped LED, switch and down-counter timer registers
// for a single-cycle processor: combinational loads, stores on the clock edge.
module data_mem_io #(
    parameter int RAM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    input  logic [9:0]  Switches,
    output logic [9:0]  Leds,
    output logic        TimerIrq
);
    localparam int AW = $clog2(RAM_WORDS);

    typedef enum logic [2:0] {
        SEL_NONE, SEL_RAM, SEL_LED, SEL_SW,
        SEL_TCTRL, SEL_TLOAD, SEL_TCOUNT, SEL_TSTAT
    } sel_e;

    logic [29:0] word_addr;
    sel_e        sel;
    logic [31:0] mem_q [RAM_WORDS];

    logic [9:0]  led_q, led_d;
    logic [9:0]  sw_meta_q, sw_sync_q;
    logic        en_q, en_d;
    logic        auto_q, auto_d;
    logic [31:0] tload_q, tload_d;
    logic [31:0] tcount_q, tcount_d;
    logic        exp_q, exp_d;
    logic        wr_led, wr_tctrl, wr_tload, wr_tstat, expire;

    // Byte-offset bits are dropped here, so every decode works on word addresses.
    assign word_addr = 30'(ALUResult >> 2);

    always_comb begin
        sel = SEL_NONE;
        if (word_addr[29:AW] == '0) begin
            sel = SEL_RAM;
        end else begin
            case (word_addr)
                30'h100: sel = SEL_LED;
                30'h101: sel = SEL_SW;
                30'h102: sel = SEL_TCTRL;
                30'h103: sel = SEL_TLOAD;
                30'h104: sel = SEL_TCOUNT;
                30'h105: sel = SEL_TSTAT;
                default: sel = SEL_NONE;
            endcase
        end
    end

    assign wr_led   = MemWrite && (sel == SEL_LED);
    assign wr_tctrl = MemWrite && (sel == SEL_TCTRL);
    assign wr_tload = MemWrite && (sel == SEL_TLOAD);
    assign wr_tstat = MemWrite && (sel == SEL_TSTAT);

    // Storage is not reset; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (!reset && MemWrite && (sel == SEL_RAM)) begin
            mem_q[word_addr[AW-1:0]] <= WriteData;
        end
    end

    always_comb begin
        ReadData = '0;
        case (sel)
            SEL_RAM:    ReadData = mem_q[word_addr[AW-1:0]];
            SEL_LED:    ReadData = {22'd0, led_q};
            SEL_SW:     ReadData = {22'd0, sw_sync_q};
            SEL_TCTRL:  ReadData = {30'd0, auto_q, en_q};
            SEL_TLOAD:  ReadData = tload_q;
            SEL_TCOUNT: ReadData = tcount_q;
            SEL_TSTAT:  ReadData = {31'd0, exp_q};
            default:    ReadData = '0;
        endcase
    end

    // A TLOAD write outranks the expiry branch, so it suppresses the expiry on that edge.
    assign expire = en_q && (tcount_q == '0) && !wr_tload;

    always_comb begin
        led_d    = led_q;
        en_d     = en_q;
        auto_d   = auto_q;
        tload_d  = tload_q;
        tcount_d = tcount_q;
        exp_d    = exp_q;

        if (wr_led) begin
            led_d = WriteData[9:0];
        end

        if (wr_tload) begin
            tload_d  = WriteData;
            tcount_d = WriteData;
        end else if (en_q && (tcount_q != '0)) begin
            tcount_d = tcount_q - 32'd1;
        end else if (expire && auto_q) begin
            tcount_d = tload_q;
        end

        if (wr_tctrl) begin
            en_d   = WriteData[0];
            auto_d = WriteData[1];
        end else if (expire && !auto_q) begin
            en_d = 1'b0;
        end

        // Expiry set beats a simultaneous write-1-to-clear.
        if (expire) begin
            exp_d = 1'b1;
        end else if (wr_tstat && WriteData[0]) begin
            exp_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            en_q      <= 1'b0;
            auto_q    <= 1'b0;
            tload_q   <= '0;
            tcount_q  <= '0;
            exp_q     <= 1'b0;
        end else begin
            led_q     <= led_d;
            sw_meta_q <= Switches;
            sw_sync_q <= sw_meta_q;
            en_q      <= en_d;
            auto_q    <= auto_d;
            tload_q   <= tload_d;
            tcount_q  <= tcount_d;
            exp_q     <= exp_d;
        end
    end

    assign Leds     = led_q;
    assign TimerIrq = exp_q;
endmodule

// File: tb/tb_data_mem_io.sv
// Self-checking bench for data_mem_io: fixed vector table, hand-written timer
// and reset sequences, then random traffic against a behavioural memory-map model.
module tb_data_mem_io;
    localparam int RAM_WORDS = 64;

    logic clk;
    logic rst;
    data_mem_io_if bus ();

    data_mem_io #(.RAM_WORDS(RAM_WORDS)) dut (
        .clk       (clk),
        .reset     (rst),
        .MemWrite  (bus.MemWrite),
        .ALUResult (bus.ALUResult),
        .WriteData (bus.WriteData),
        .ReadData  (bus.ReadData),
        .Switches  (bus.Switches),
        .Leds      (bus.Leds),
        .TimerIrq  (bus.TimerIrq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the memory map
    logic [31:0] m_ram [RAM_WORDS];
    bit          m_vld [RAM_WORDS];
    logic [9:0]  m_led, m_sw1, m_sw2;
    bit          m_en, m_auto, m_exp;
    logic [31:0] m_tload, m_tcount;

    function automatic bit in_ram(logic [31:0] a);
        return (a >> 2) < RAM_WORDS;
    endfunction

    function automatic bit m_known(logic [31:0] a);
        if (in_ram(a)) return m_vld[a[31:2] % RAM_WORDS];
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_read(logic [31:0] a);
        logic [31:0] w;
        w = a >> 2;
        if (in_ram(a)) return m_ram[w];
        if (a[31:2] == 30'h100) return {22'd0, m_led};
        if (a[31:2] == 30'h101) return {22'd0, m_sw2};
        if (a[31:2] == 30'h102) return {30'd0, m_auto, m_en};
        if (a[31:2] == 30'h103) return m_tload;
        if (a[31:2] == 30'h104) return m_tcount;
        if (a[31:2] == 30'h105) return {31'd0, m_exp};
        return 32'd0;
    endfunction

    task automatic m_edge(bit r, bit we, logic [31:0] a, logic [31:0] d, logic [9:0] sw);
        bit hit_load, fires;
        logic [31:0] w;
        if (r) begin
            m_led = 0; m_sw1 = 0; m_sw2 = 0; m_en = 0; m_auto = 0;
            m_tload = 0; m_tcount = 0; m_exp = 0;
            return;
        end
        w = a >> 2;
        hit_load = we && (w == 32'h103);
        fires = m_en && (m_tcount == 0) && !hit_load;
        m_sw2 = m_sw1;
        m_sw1 = sw;
        if (we && in_ram(a)) begin m_ram[w] = d; m_vld[w] = 1; end
        if (we && w == 32'h100) m_led = d[9:0];
        // Count: a load replaces it, a running timer steps toward zero, expiry reloads or parks at zero
        if (hit_load) begin
            m_tload = d; m_tcount = d;
        end else if (m_en) begin
            if (m_tcount > 0) m_tcount = m_tcount - 1;
            else if (m_auto) m_tcount = m_tload;
        end
        if (we && w == 32'h102) begin
            m_en = d[0]; m_auto = d[1];
        end else if (fires && !m_auto) begin
            m_en = 0;
        end
        if (fires) m_exp = 1;
        else if (we && w == 32'h105 && d[0]) m_exp = 0;
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, expv);
        end
    endtask

    // Called at posedge+1. Checks the pre-edge load, clocks, then checks the outputs.
    task automatic step(string tag, bit r, bit we, logic [31:0] a, logic [31:0] d,
                        logic [9:0] sw, bit chk_rd, logic [31:0] erd,
                        bit use_model, logic [9:0] eleds, bit eirq);
        rst = r;
        bus.MemWrite  = we;
        bus.ALUResult = a;
        bus.WriteData = d;
        bus.Switches  = sw;
        #2;
        $display("%s: rst=%0d we=%0d addr=%h wdata=%h rd=%h", tag, r, we, a, d, bus.ReadData);
        if (chk_rd) chk({tag, " ReadData"}, bus.ReadData, erd);
        @(posedge clk);
        m_edge(r, we, a, d, sw);
        #1;
        if (use_model) begin
            eleds = m_led;
            eirq  = m_exp;
        end
        chk({tag, " Leds"}, {22'd0, bus.Leds}, {22'd0, eleds});
        chk({tag, " TimerIrq"}, {31'd0, bus.TimerIrq}, {31'd0, eirq});
    endtask

    typedef struct {
        bit          rst;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [9:0]  sw;
        bit          chk_rd;
        logic [31:0] rd;
        logic [9:0]  leds;
        bit          irq;
    } vec_t;

    function automatic vec_t mk(bit r, bit we, logic [31:0] a, logic [31:0] d, logic [9:0] sw,
                                bit c, logic [31:0] rd, logic [9:0] leds, bit irq);
        vec_t v;
        v.rst = r; v.we = we; v.addr = a; v.wdata = d; v.sw = sw;
        v.chk_rd = c; v.rd = rd; v.leds = leds; v.irq = irq;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        logic [9:0]  sw_cur;
        logic [31:0] a, d;
        bit          we, r;
        int          kind;

        for (int i = 0; i < RAM_WORDS; i++) m_vld[i] = 0;
        rst = 1; bus.MemWrite = 0; bus.ALUResult = 0; bus.WriteData = 0; bus.Switches = 0;
        m_edge(1, 0, 0, 0, 0);

        vecs.push_back(mk(1, 0, 32'h400, 0, 10'h000, 0, 0, 10'h000, 0));
        vecs.push_back(mk(0, 1, 32'h03C, 32'hDEADBEEF, 10'h000, 0, 0, 10'h000, 0));
        vecs.push_back(mk(0, 0, 32'h03C, 0, 10'h000, 1, 32'hDEADBEEF, 10'h000, 0));
        vecs.push_back(mk(0, 0, 32'h03E, 0, 10'h000, 1, 32'hDEADBEEF, 10'h000, 0));
        vecs.push_back(mk(0, 1, 32'h040, 32'h11111111, 10'h000, 0, 0, 10'h000, 0));
        vecs.push_back(mk(0, 0, 32'h03C, 0, 10'h000, 1, 32'hDEADBEEF, 10'h000, 0));
        vecs.push_back(mk(0, 0, 32'h040, 0, 10'h000, 1, 32'h11111111, 10'h000, 0));
        vecs.push_back(mk(0, 1, 32'h400, 32'h2A5, 10'h000, 1, 0, 10'h2A5, 0));
        vecs.push_back(mk(0, 0, 32'h400, 0, 10'h000, 1, 32'h2A5, 10'h2A5, 0));
        vecs.push_back(mk(0, 1, 32'h800, 32'h12345678, 10'h000, 1, 0, 10'h2A5, 0));
        vecs.push_back(mk(0, 0, 32'h800, 0, 10'h000, 1, 0, 10'h2A5, 0));
        vecs.push_back(mk(0, 1, 32'h100, 32'hA5A5A5A5, 10'h000, 1, 0, 10'h2A5, 0));
        vecs.push_back(mk(0, 1, 32'h404, 32'h3FF, 10'h000, 1, 0, 10'h2A5, 0));
        vecs.push_back(mk(0, 0, 32'h404, 0, 10'h155, 1, 0, 10'h2A5, 0));
        vecs.push_back(mk(0, 0, 32'h404, 0, 10'h155, 1, 0, 10'h2A5, 0));
        vecs.push_back(mk(0, 0, 32'h404, 0, 10'h155, 1, 32'h155, 10'h2A5, 0));
        vecs.push_back(mk(0, 0, 32'h407, 0, 10'h155, 1, 32'h155, 10'h2A5, 0));
        vecs.push_back(mk(0, 0, 32'h408, 0, 10'h155, 1, 0, 10'h2A5, 0));
        vecs.push_back(mk(0, 0, 32'h410, 0, 10'h155, 1, 0, 10'h2A5, 0));
        vecs.push_back(mk(0, 0, 32'h414, 0, 10'h155, 1, 0, 10'h2A5, 0));
        vecs.push_back(mk(0, 0, 32'h418, 0, 10'h155, 1, 0, 10'h2A5, 0));
        vecs.push_back(mk(0, 0, 32'h03C, 0, 10'h155, 1, 32'hDEADBEEF, 10'h2A5, 0));

        @(posedge clk); #1;
        foreach (vecs[i])
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                 vecs[i].sw, vecs[i].chk_rd, vecs[i].rd, 0, vecs[i].leds, vecs[i].irq);
        sw_cur = 10'h155;

        // One-shot: 3,2,1,0 then expiry clears EN and parks the count at zero
        step("os_rst",   1, 0, 32'h000, 0, sw_cur, 0, 0, 0, 10'h000, 0);
        step("os_load",  0, 1, 32'h40C, 3, sw_cur, 1, 0, 0, 10'h000, 0);
        step("os_ctrl",  0, 1, 32'h408, 1, sw_cur, 1, 0, 0, 10'h000, 0);
        step("os_c3",    0, 0, 32'h410, 0, sw_cur, 1, 3, 0, 10'h000, 0);
        step("os_c2",    0, 0, 32'h410, 0, sw_cur, 1, 2, 0, 10'h000, 0);
        step("os_c1",    0, 0, 32'h410, 0, sw_cur, 1, 1, 0, 10'h000, 0);
        step("os_c0",    0, 0, 32'h410, 0, sw_cur, 1, 0, 0, 10'h000, 1);
        step("os_en",    0, 0, 32'h408, 0, sw_cur, 1, 0, 0, 10'h000, 1);
        step("os_hold",  0, 0, 32'h410, 0, sw_cur, 1, 0, 0, 10'h000, 1);
        step("os_stat",  0, 0, 32'h414, 0, sw_cur, 1, 1, 0, 10'h000, 1);
        step("os_w1c",   0, 1, 32'h414, 1, sw_cur, 1, 1, 0, 10'h000, 0);
        step("os_clr",   0, 0, 32'h414, 0, sw_cur, 1, 0, 0, 10'h000, 0);

        // Autoreload period 3, with a W1C colliding with an expiry
        step("ar_rst",   1, 0, 32'h000, 0, sw_cur, 0, 0, 0, 10'h000, 0);
        step("ar_load",  0, 1, 32'h40C, 2, sw_cur, 1, 0, 0, 10'h000, 0);
        step("ar_ctrl",  0, 1, 32'h408, 3, sw_cur, 1, 0, 0, 10'h000, 0);
        step("ar_c2",    0, 0, 32'h410, 0, sw_cur, 1, 2, 0, 10'h000, 0);
        step("ar_c1",    0, 0, 32'h410, 0, sw_cur, 1, 1, 0, 10'h000, 0);
        step("ar_c0",    0, 0, 32'h410, 0, sw_cur, 1, 0, 0, 10'h000, 1);
        step("ar_w1c",   0, 1, 32'h414, 1, sw_cur, 1, 1, 0, 10'h000, 0);
        step("ar_c1b",   0, 0, 32'h410, 0, sw_cur, 1, 1, 0, 10'h000, 0);
        step("ar_w1cx",  0, 1, 32'h414, 1, sw_cur, 1, 0, 0, 10'h000, 1);
        step("ar_c2b",   0, 0, 32'h410, 0, sw_cur, 1, 2, 0, 10'h000, 1);
        step("ar_ctrlr", 0, 0, 32'h408, 0, sw_cur, 1, 3, 0, 10'h000, 1);

        // Reset in mid-count with a competing LED write
        step("rm_rst",   1, 0, 32'h000, 0, sw_cur, 0, 0, 0, 10'h000, 0);
        step("rm_ram",   0, 1, 32'h000, 32'hCAFEF00D, sw_cur, 0, 0, 0, 10'h000, 0);
        step("rm_led",   0, 1, 32'h400, 32'h3FF, sw_cur, 1, 0, 0, 10'h3FF, 0);
        step("rm_load",  0, 1, 32'h40C, 6, sw_cur, 1, 0, 0, 10'h3FF, 0);
        step("rm_ctrl",  0, 1, 32'h408, 1, sw_cur, 1, 0, 0, 10'h3FF, 0);
        step("rm_c6",    0, 0, 32'h410, 0, sw_cur, 1, 6, 0, 10'h3FF, 0);
        step("rm_c5",    0, 0, 32'h410, 0, sw_cur, 1, 5, 0, 10'h3FF, 0);
        step("rm_hit",   1, 1, 32'h400, 32'h155, sw_cur, 1, 32'h3FF, 0, 10'h000, 0);
        step("rm_cnt",   0, 0, 32'h410, 0, sw_cur, 1, 0, 0, 10'h000, 0);
        step("rm_ctl",   0, 0, 32'h408, 0, sw_cur, 1, 0, 0, 10'h000, 0);
        step("rm_ram0",  0, 0, 32'h000, 0, sw_cur, 1, 32'hCAFEF00D, 0, 10'h000, 0);
        step("rm_stat",  0, 0, 32'h414, 0, sw_cur, 1, 0, 0, 10'h000, 0);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            kind = $urandom_range(0, 9);
            if (kind < 5) a = {22'd0, 6'($urandom_range(0, RAM_WORDS - 1)), 2'($urandom_range(0, 3))};
            else if (kind < 9) a = 32'h400 + 4 * $urandom_range(0, 5);
            else a = ($urandom_range(0, 1) == 1) ? 32'h0000_0800 : 32'hFFFF_FFFC;
            we = ($urandom_range(0, 1) == 1);
            d = $urandom;
            if (a == 32'h40C) d = $urandom_range(0, 6);
            if ($urandom_range(0, 7) == 0) sw_cur = 10'($urandom);
            r = ($urandom_range(0, 99) == 0);
            step($sformatf("rnd%0d", n), r, we, a, d, sw_cur, m_known(a), m_read(a), 1, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_mem_io.md
DATA_MEM_IO -- requirements
Module: data_mem_io

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 64, meaning the number of 32-bit data RAM words (power of two, maximum 256).
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port MemWrite, input, 1 bit: store strobe from the processor.
REQ-005 SHALL have port ALUResult, input, 32 bits: byte address from the processor.
REQ-006 SHALL have port WriteData, input, 32 bits: store data.
REQ-007 SHALL have port ReadData, output, 32 bits: load data, combinational from the address and current state.
REQ-008 SHALL have port Switches, input, 10 bits: asynchronous board switches.
REQ-009 SHALL have port Leds, output, 10 bits: the LED register.
REQ-010 SHALL have port TimerIrq, output, 1 bit: the timer expired flag.

Function
REQ-011 SHALL decode the address map on ALUResult[31:2], ignoring bits [1:0]:
- RAM: 0x000..(4*RAM_WORDS-4), index ALUResult[log2(RAM_WORDS)+1:2]
- 0x400 LED (RW, bits [9:0])
- 0x404 SW (RO)
- 0x408 TCTRL (RW: bit0 EN, bit1 AUTO)
- 0x40C TLOAD (RW, 32 bits)
- 0x410 TCOUNT (RO)
- 0x414 TSTAT (bit0 EXP, write-1-to-clear)
REQ-012 SHALL return 0 on ReadData for unmapped addresses and for unused register bits; writes to unmapped or RO addresses SHALL have no effect.
REQ-013 SHALL perform a write only on a rising clk edge with MemWrite=1 and reset=0, to exactly one target; ReadData SHALL reflect the pre-edge value during the write cycle (read-before-write).
REQ-014 SHALL drive ReadData combinationally (zero-latency load) so that a single-cycle processor completes a load in one cycle.
REQ-015 SHALL synchronize Switches through two flip-flop stages; SW reads return the second stage, so a switch change becomes visible 2 edges later.
REQ-016 SHALL drive Leds directly from the LED register and TimerIrq directly from EXP.
REQ-017 SHALL implement a 32-bit down counter, TCOUNT, updated each edge by priority:
- (a) write TLOAD: TCOUNT<=WriteData.
- (b) else EN=1 and TCOUNT!=0: TCOUNT<=TCOUNT-1.
- (c) else EN=1 and TCOUNT==0: set EXP; if AUTO=1, TCOUNT<=TLOAD; if AUTO=0, TCOUNT holds 0 and EN<=0.
- (d) else hold.
REQ-018 SHALL, on the same edge as an expiry and a W1C write to TSTAT, leave EXP=1 (set wins over clear).
REQ-019 SHALL apply a write to TCTRL that sets EN=1 from the next edge; a TCTRL write on the same edge as an AUTO=0 expiry takes the written EN value.
REQ-020 SHALL never underflow TCOUNT below 0; TLOAD=0 with AUTO=1 and EN=1 SHALL set EXP on every edge.
REQ-021 SHALL implement the RAM as synchronous-write, asynchronous-read storage with no byte enables.

Reset
REQ-022 SHALL, on reset=1 at an edge, clear LED, TCTRL, TLOAD, TCOUNT, EXP and both switch synchronizer stages to 0; Leds=0 and TimerIrq=0 after that edge.
REQ-023 SHALL NOT clear RAM contents on reset.
REQ-024 SHALL give reset priority over any simultaneous MemWrite, so that no write takes effect on a reset edge.
REQ-025 SHALL stop a timer in mid-count on reset: TCOUNT=0 and EN=0, with no EXP pulse.

Verification
REQ-026 RAM: write 0xDEADBEEF at 0x3C, then read 0x3C -> 0xDEADBEEF. Read 0x40 -> unaffected. Read 0x3E -> 0xDEADBEEF (low bits ignored).
REQ-027 LED/SW: write 0x2A5 to 0x400 -> Leds=0x2A5 next cycle. Switches=0x155 -> read 0x404 =0 for 1 edge, =0x155 from the 2nd edge on.
REQ-028 Timer one-shot: TLOAD=3, TCTRL=0x1 -> TCOUNT sequence 3,2,1,0, then EXP=1 and EN=0; TCOUNT stays 0; write 0x1 to 0x414 -> TimerIrq=0.
REQ-029 Timer autoreload: TLOAD=2, TCTRL=0x3 -> EXP set every 3 edges and TCOUNT=2,1,0,2,... A W1C write on the expiry edge -> EXP remains 1.
REQ-030 Reset mid-operation: timer running at TCOUNT=5 with Leds=0x3FF; assert reset for 1 edge with MemWrite=1 to 0x400 -> Leds=0, TCOUNT=0, TimerIrq=0, and RAM word 0 keeps its prior value.
REQ-031 Unmapped: write 0x12345678 to 0x800 -> no state change, and read 0x800 returns 0.
